// File: rtl/busy_ram_pkg.sv
// busy_ram_pkg: shared types and constants for the wait-state RAM.
//   state_e  - access FSM states
//   MAX_LAT  - largest supported read/write latency
//   LAT_W    - width of the wait-state counter
//   WORD_W   - data word width
//   LANES    - byte lanes per word
package busy_ram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  localparam int unsigned MAX_LAT = 15;
  localparam int unsigned LAT_W   = 4;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LANES   = WORD_W / 8;

endpackage

// File: rtl/busy_ram_array.sv
// busy_ram_array: byte-enabled word storage with one write port and one
// registered read port sharing a single word index.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset (clears the read register only)
//   idx    - word index
//   we     - write enable; lanes selected by wmask
//   wmask  - byte-lane enables
//   wdata  - write data
//   re     - read enable; loads rdata from mem[idx]
//   rdata  - registered read data, held between reads
module busy_ram_array
  import busy_ram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic                  we,
  input  logic [LANES-1:0]      wmask,
  input  logic [WORD_W-1:0]     wdata,
  input  logic                  re,
  output logic [WORD_W-1:0]     rdata
);

  // Storage is deliberately not reset.
  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (wmask[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/busy_ram.sv
// busy_ram: single-port word RAM on the strobe/busy bus that inserts
// READ_LAT-1 / WRITE_LAT-1 wait states, signalled on rbusy / wbusy.
// Optional macro BUSY_RAM_CHECK_EN adds the sticky proto_err output.
// Parameters:
//   DEPTH_LOG2 - log2 of number of 32-bit words
//   READ_LAT   - edges from accepted rstrb to rdata update (1..15)
//   WRITE_LAT  - edges from accepted wstrb to write commit (1..15)
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   addr       - byte address; word index addr[DEPTH_LOG2+1:2]
//   wmask      - byte-lane write enables
//   rstrb      - one-cycle read request
//   wstrb      - one-cycle write request
//   rdata      - registered read data
//   wdata      - write data
//   rbusy      - read pending
//   wbusy      - write pending
//   proto_err  - (BUSY_RAM_CHECK_EN only) sticky protocol-violation flag
module busy_ram
  import busy_ram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned WRITE_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [LANES-1:0]  wmask,
  input  logic              rstrb,
  input  logic              wstrb,
  output logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] wdata,
  output logic              rbusy,
  output logic              wbusy
`ifdef BUSY_RAM_CHECK_EN
  ,
  output logic              proto_err
`endif
);

  localparam logic [LAT_W-1:0] RdLoad = LAT_W'(READ_LAT - 1);
  localparam logic [LAT_W-1:0] WrLoad = LAT_W'(WRITE_LAT - 1);
  localparam logic [LAT_W-1:0] CntOne = LAT_W'(1);

  state_e                  state_q, state_d;
  logic [LAT_W-1:0]        cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;
  logic [LANES-1:0]        wmask_q, wmask_d;

  logic                    arr_we, arr_re;
  logic [DEPTH_LOG2-1:0]   arr_idx;
  logic [WORD_W-1:0]       arr_wdata;
  logic [LANES-1:0]        arr_wmask;

  logic [DEPTH_LOG2-1:0]   idx_in;
  logic                    unused_addr;

  // Upper address bits wrap; byte offset is ignored.
  assign idx_in      = addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_idx   = idx_q;
    arr_wdata = wdata_q;
    arr_wmask = wmask_q;

    unique case (state_q)
      IDLE: begin
        // Write wins a simultaneous request; the read is dropped.
        if (wstrb || rstrb) begin
          idx_d   = idx_in;
          wdata_d = wdata;
          wmask_d = wmask;
        end
        if (wstrb) begin
          if (WRITE_LAT == 1) begin
            // Single-cycle: commit straight from the bus at the accepting edge.
            arr_we    = 1'b1;
            arr_idx   = idx_in;
            arr_wdata = wdata;
            arr_wmask = wmask;
          end else begin
            cnt_d   = WrLoad;
            state_d = WR_WAIT;
          end
        end else if (rstrb) begin
          if (READ_LAT == 1) begin
            arr_re  = 1'b1;
            arr_idx = idx_in;
          end else begin
            cnt_d   = RdLoad;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == CntOne) begin
          arr_re  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      WR_WAIT: begin
        if (cnt_q == CntOne) begin
          arr_we  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  // Busy comes straight from the state register so reset clears it at once.
  assign rbusy = (state_q == RD_WAIT);
  assign wbusy = (state_q == WR_WAIT);

  busy_ram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .idx   (arr_idx),
    .we    (arr_we),
    .wmask (arr_wmask),
    .wdata (arr_wdata),
    .re    (arr_re),
    .rdata (rdata)
  );

`ifdef BUSY_RAM_CHECK_EN
  logic perr_q;
  logic violation;

  assign violation = ((state_q != IDLE) && (rstrb || wstrb)) || (rstrb && wstrb);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_q <= 1'b0;
    end else if (violation) begin
      perr_q <= 1'b1;
    end
  end

  assign proto_err = perr_q;
`endif

endmodule

// File: tb/tb_busy_ram.sv
// tb_busy_ram: self-checking bench for busy_ram.
// Three instances: #0 READ_LAT=1/WRITE_LAT=1, #1 READ_LAT=3/WRITE_LAT=4 with
// DEPTH_LOG2=4, #2 READ_LAT=4/WRITE_LAT=2. proto_err is checked only when
// BUSY_RAM_CHECK_EN is defined.
module tb_busy_ram;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n, rstrb, wstrb, rbusy, wbusy;
  logic [31:0] addr, wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata [3];
`ifdef BUSY_RAM_CHECK_EN
  logic [2:0]  perr;
`endif

  int checks   = 0;
  int failures = 0;

  busy_ram #(.DEPTH_LOG2(10), .READ_LAT(1), .WRITE_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst_n[0]), .addr(addr), .wmask(wmask), .rstrb(rstrb[0]),
    .wstrb(wstrb[0]), .rdata(rdata[0]), .wdata(wdata), .rbusy(rbusy[0]), .wbusy(wbusy[0])
`ifdef BUSY_RAM_CHECK_EN
    , .proto_err(perr[0])
`endif
  );

  busy_ram #(.DEPTH_LOG2(4), .READ_LAT(3), .WRITE_LAT(4)) u_dut1 (
    .clk(clk), .rst(rst_n[1]), .addr(addr), .wmask(wmask), .rstrb(rstrb[1]),
    .wstrb(wstrb[1]), .rdata(rdata[1]), .wdata(wdata), .rbusy(rbusy[1]), .wbusy(wbusy[1])
`ifdef BUSY_RAM_CHECK_EN
    , .proto_err(perr[1])
`endif
  );

  busy_ram #(.DEPTH_LOG2(10), .READ_LAT(4), .WRITE_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst_n[2]), .addr(addr), .wmask(wmask), .rstrb(rstrb[2]),
    .wstrb(wstrb[2]), .rdata(rdata[2]), .wdata(wdata), .rbusy(rbusy[2]), .wbusy(wbusy[2])
`ifdef BUSY_RAM_CHECK_EN
    , .proto_err(perr[2])
`endif
  );

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One-cycle strobe; returns #1 after the accepting edge.
  task automatic access(input int i, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    addr     = a;
    wmask    = m;
    wdata    = d;
    wstrb[i] = wr;
    rstrb[i] = rd;
    @(posedge clk);
    #1;
    wstrb[i] = 1'b0;
    rstrb[i] = 1'b0;
  endtask

  // Counts remaining sampled cycles with busy high (bounded).
  task automatic count_busy(input int i, output int n);
    n = 0;
    while ((rbusy[i] | wbusy[i]) && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;

    rst_n = '0;
    rstrb = '0;
    wstrb = '0;
    addr  = '0;
    wdata = '0;
    wmask = '0;

    vecs[0]  = '{1'b1, 1'b0, 32'h10,   4'hF, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b1, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h14,   4'hF, 32'h11223344, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h14,   4'h2, 32'h0000AB00, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b1, 32'h14,   4'h0, 32'h0,        32'h1122AB44};
    vecs[5]  = '{1'b1, 1'b0, 32'h14,   4'h9, 32'hFF0000EE, 32'h1122AB44};
    vecs[6]  = '{1'b0, 1'b1, 32'h14,   4'h0, 32'h0,        32'hFF22ABEE};
    vecs[7]  = '{1'b1, 1'b0, 32'h18,   4'hF, 32'h55667788, 32'hFF22ABEE};
    vecs[8]  = '{1'b1, 1'b0, 32'h18,   4'h0, 32'hAABBCCDD, 32'hFF22ABEE};
    vecs[9]  = '{1'b0, 1'b1, 32'h1B,   4'h0, 32'h0,        32'h55667788};
    vecs[10] = '{1'b0, 1'b1, 32'h1010, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[11] = '{1'b1, 1'b1, 32'h1C,   4'hF, 32'h0BADF00D, 32'hDEADBEEF};
    vecs[12] = '{1'b0, 1'b1, 32'h1C,   4'h0, 32'h0,        32'h0BADF00D};

    // Reset values
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_rdata%0d", i), rdata[i], 32'h0);
      check($sformatf("reset_busy%0d", i), 32'({rbusy[i], wbusy[i]}), 32'h0);
`ifdef BUSY_RAM_CHECK_EN
      check($sformatf("reset_perr%0d", i), 32'(perr[i]), 32'h0);
`endif
    end
    @(negedge clk);
    rst_n = '1;

    // Latency-1 instance: table-driven
    for (int v = 0; v < 13; v++) begin
      access(0, vecs[v].wr, vecs[v].rd, vecs[v].a, vecs[v].m, vecs[v].d);
      check($sformatf("lat1_rdata_v%0d", v), rdata[0], vecs[v].exp);
      check($sformatf("lat1_busy_v%0d", v), 32'({rbusy[0], wbusy[0]}), 32'h0);
`ifdef BUSY_RAM_CHECK_EN
      if (v == 10) check("lat1_perr_clean", 32'(perr[0]), 32'h0);
      if (v == 11) check("lat1_perr_simul", 32'(perr[0]), 32'h1);
`endif
    end

    // Instance 1: WRITE_LAT=4, READ_LAT=3, 16 words
    access(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
    check("wl4_wbusy_rise", 32'({rbusy[1], wbusy[1]}), 32'h1);
    count_busy(1, n);
    check("wl4_busy_cycles", 32'(n), 32'd3);
    check("wl4_rdata_untouched", rdata[1], 32'h0);

    access(1, 1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
    check("rl3_rbusy_rise", 32'({rbusy[1], wbusy[1]}), 32'h2);
    check("rl3_rdata_not_early", rdata[1], 32'h0);
    count_busy(1, n);
    check("rl3_busy_cycles", 32'(n), 32'd2);
    check("rl3_rdata", rdata[1], 32'hDEADBEEF);

    access(1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h12345678);
    count_busy(1, n);
    access(1, 1'b0, 1'b1, 32'h00, 4'h0, 32'h0);
    count_busy(1, n);
    check("depth4_wrap", rdata[1], 32'h12345678);

    access(1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h00000000);
    count_busy(1, n);
    access(1, 1'b1, 1'b0, 32'h20, 4'hF, 32'hCAFEF00D);
    @(posedge clk);
    #3;
    check("rst_mid_wbusy_before", 32'(wbusy[1]), 32'h1);
    rst_n[1] = 1'b0;
    #1;
    check("rst_mid_wbusy_async", 32'(wbusy[1]), 32'h0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    access(1, 1'b0, 1'b1, 32'h20, 4'h0, 32'h0);
    count_busy(1, n);
    check("rst_mid_no_commit", rdata[1], 32'h00000000);

    // Instance 2: READ_LAT=4, strobes while busy
    access(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'hAAAA0001);
    count_busy(2, n);
    check("wl2_busy_cycles", 32'(n), 32'd1);
    access(2, 1'b1, 1'b0, 32'h24, 4'hF, 32'hBBBB0002);
    count_busy(2, n);
`ifdef BUSY_RAM_CHECK_EN
    check("rl4_perr_clean", 32'(perr[2]), 32'h0);
`endif
    access(2, 1'b0, 1'b1, 32'h20, 4'h0, 32'h0);
    check("rl4_rbusy_rise", 32'(rbusy[2]), 32'h1);
    access(2, 1'b0, 1'b1, 32'h24, 4'h0, 32'h0);
    count_busy(2, n);
    check("rl4_busy_remaining", 32'(n), 32'd2);
    check("rl4_ignored_rstrb", rdata[2], 32'hAAAA0001);
`ifdef BUSY_RAM_CHECK_EN
    check("rl4_perr_set", 32'(perr[2]), 32'h1);
`endif
    access(2, 1'b0, 1'b1, 32'h24, 4'h0, 32'h0);
    access(2, 1'b1, 1'b0, 32'h24, 4'hF, 32'hDEAD0000);
    count_busy(2, n);
    check("rl4_read2", rdata[2], 32'hBBBB0002);
    access(2, 1'b0, 1'b1, 32'h24, 4'h0, 32'h0);
    count_busy(2, n);
    check("rl4_busy_cycles", 32'(n), 32'd3);
    check("rl4_ignored_wstrb", rdata[2], 32'hBBBB0002);
`ifdef BUSY_RAM_CHECK_EN
    check("rl4_perr_sticky", 32'(perr[2]), 32'h1);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    check("rl4_perr_reset", 32'(perr[2]), 32'h0);
    rst_n[2] = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
